mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of BUSY cycles without ack before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port i_MEM_dmemWe, input, 1 bit: store request from EXE.
REQ-005 SHALL have ports i_MEM_regWe, i_MEM_sByte and i_MEM_sWRD, input, 1 bit each: register write enable, byte access, and writeback select (0 = ALU result, 1 = memory data).
REQ-006 SHALL have port i_MEM_WRA, input, 5 bits: destination register.
REQ-007 SHALL have ports i_MEM_aluOut and i_MEM_rd2, input, 32 bits each: address or result, and store data.
REQ-008 SHALL have memory-bus ports: o_MEM_req (out, 1), o_MEM_we (out, 1), o_MEM_addr (out, 32), o_MEM_wdata (out, 32), o_MEM_be (out, 4), i_MEM_ack (in, 1), i_MEM_rdata (in, 32).
REQ-009 SHALL have writeback ports o_MEM_regWe (out, 1), o_MEM_WRA (out, 5) and o_MEM_WD (out, 32).
REQ-010 SHALL have port o_MEM_stall (out, 1): freezes upstream stages; and port o_MEM_err (out, 1): sticky bus-timeout flag.

Function
REQ-011 SHALL capture all i_MEM_* pipeline inputs into a stage register on each rising edge while o_MEM_stall is 0, and hold them while o_MEM_stall is 1.
REQ-012 SHALL classify the captured operation as a load (regWe & sWRD), a store (dmemWe), or an ALU op (neither); load and store together SHALL be treated as a store with regWe suppressed.
REQ-013 SHALL implement the FSM IDLE -> BUSY (captured op is load/store) -> IDLE (on ack or abort); an ALU op SHALL remain in IDLE.
REQ-014 An ALU op captured at edge k SHALL present o_MEM_regWe = captured regWe, o_MEM_WRA and o_MEM_WD = aluOut, registered at edge k+1.
REQ-015 In BUSY: o_MEM_req = 1, o_MEM_we = store, o_MEM_stall = 1, and o_MEM_regWe = 0 (bubble) each cycle until the ack cycle inclusive.
REQ-016 Word access: o_MEM_addr = {aluOut[31:2], 2'b00}, o_MEM_be = 4'hF, o_MEM_wdata = rd2.
REQ-017 Byte access: o_MEM_addr = aluOut, o_MEM_be = 1 << aluOut[1:0], o_MEM_wdata = {4{rd2[7:0]}}.
REQ-018 Load data: word = i_MEM_rdata; byte = the lane aluOut[1:0] sign-extended to 32 bits; it SHALL be sampled in the ack cycle only.
REQ-019 On the ack edge: o_MEM_regWe = 1 with o_MEM_WD = load data for a load, or o_MEM_regWe = 0 for a store; the FSM returns to IDLE and o_MEM_stall falls in the next cycle.
REQ-020 A single-cycle ack (ack in the first BUSY cycle) SHALL complete the access in that cycle; the minimum memory-op latency is 2 edges after capture.
REQ-021 i_MEM_ack while o_MEM_req = 0 SHALL be ignored.
REQ-022 Bus outputs SHALL be 0 (o_MEM_be = 4'h0) whenever o_MEM_req = 0.
REQ-023 Back-to-back memory ops: the next op SHALL be captured on the edge on which o_MEM_stall deasserts, and its request SHALL start the following cycle.

Reset
REQ-024 rstn low SHALL immediately clear all registers, force the FSM to IDLE, and drive o_MEM_req, o_MEM_we, o_MEM_stall, o_MEM_regWe, o_MEM_err, o_MEM_be, o_MEM_WRA, o_MEM_WD and o_MEM_addr to 0, including mid-access (the request is dropped, not completed).
REQ-025 After rstn rises, the first capture SHALL occur on the next rising edge.

Configuration
REQ-026 With macro MEM_TIMEOUT_EN defined: a counter SHALL count BUSY cycles; if TIMEOUT_CYCLES cycles pass without ack, the access SHALL abort, with req dropped, o_MEM_regWe = 0, o_MEM_err set to 1 (sticky until reset), stall released, and FSM to IDLE.
REQ-027 Without MEM_TIMEOUT_EN: BUSY SHALL wait indefinitely for ack, o_MEM_err SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-028 ALU op, regWe=1, WRA=5, aluOut=0x1234 -> one edge later o_MEM_regWe=1, WRA=5, WD=0x1234, and stall never asserts.
REQ-029 Word load at aluOut=0x103, ack after 3 cycles with rdata=0xDEADBEEF -> addr=0x100, be=F, stall high for 3 cycles, then WD=0xDEADBEEF with regWe=1.
REQ-030 Byte store at aluOut=0x22, rd2=0x000000A5, immediate ack -> be=4'b0100, wdata=0xA5A5A5A5, we=1, and o_MEM_regWe=0.
REQ-031 Byte load at aluOut=0x41, rdata=0x0000_80_00 -> WD=0xFFFFFF80.
REQ-032 rstn pulsed low during the 2nd BUSY cycle -> req, stall and regWe go 0 immediately; a late ack after release is ignored.
REQ-033 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, a load with no ack -> req drops after 16 cycles, o_MEM_err=1 and stays 1, regWe=0, and the next op proceeds normally.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: stage register, bus FSM and load/store writeback.
// Optional bus timeout/abort with sticky error is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_MEM_dmemWe,
  input  logic        i_MEM_regWe,
  input  logic        i_MEM_sByte,
  input  logic        i_MEM_sWRD,
  input  logic [4:0]  i_MEM_WRA,
  input  logic [31:0] i_MEM_aluOut,
  input  logic [31:0] i_MEM_rd2,
  output logic        o_MEM_req,
  output logic        o_MEM_we,
  output logic [31:0] o_MEM_addr,
  output logic [31:0] o_MEM_wdata,
  output logic [3:0]  o_MEM_be,
  input  logic        i_MEM_ack,
  input  logic [31:0] i_MEM_rdata,
  output logic        o_MEM_regWe,
  output logic [4:0]  o_MEM_WRA,
  output logic [31:0] o_MEM_WD,
  output logic        o_MEM_stall,
  output logic        o_MEM_err
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic        s_dmem_we, s_reg_we, s_sbyte, s_swrd;
  logic [4:0]  s_wra;
  logic [31:0] s_alu, s_rd2;

  logic        b_load, b_byte;
  logic [4:0]  b_wra;

  logic        is_store, is_load, expire;
  logic [7:0]  lane;
  logic [31:0] load_data;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // A simultaneous load+store request is a store; the load half is dropped.
  assign is_store = s_dmem_we;
  assign is_load  = s_reg_we & s_swrd & ~s_dmem_we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_dmem_we <= 1'b0;
      s_reg_we  <= 1'b0;
      s_sbyte   <= 1'b0;
      s_swrd    <= 1'b0;
      s_wra     <= 5'd0;
      s_alu     <= 32'd0;
      s_rd2     <= 32'd0;
    end else if (!o_MEM_stall) begin
      s_dmem_we <= i_MEM_dmemWe;
      s_reg_we  <= i_MEM_regWe;
      s_sbyte   <= i_MEM_sByte;
      s_swrd    <= i_MEM_sWRD;
      s_wra     <= i_MEM_WRA;
      s_alu     <= i_MEM_aluOut;
      s_rd2     <= i_MEM_rd2;
    end
  end

  // For byte accesses the bus address is unaligned, so its low bits pick the lane.
  always_comb begin
    lane = i_MEM_rdata[7:0];
    case (o_MEM_addr[1:0])
      2'd1:    lane = i_MEM_rdata[15:8];
      2'd2:    lane = i_MEM_rdata[23:16];
      2'd3:    lane = i_MEM_rdata[31:24];
      default: lane = i_MEM_rdata[7:0];
    endcase
    load_data = b_byte ? {{24{lane[7]}}, lane} : i_MEM_rdata;
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] busy_cnt;

  assign expire = (state == BUSY) && !i_MEM_ack && (busy_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_cnt  <= 32'd0;
      o_MEM_err <= 1'b0;
    end else begin
      if (state == BUSY && !i_MEM_ack && !expire) busy_cnt <= busy_cnt + 32'd1;
      else                                        busy_cnt <= 32'd0;
      if (expire) o_MEM_err <= 1'b1;
    end
  end
`else
  assign expire    = 1'b0;
  assign o_MEM_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      o_MEM_req   <= 1'b0;
      o_MEM_we    <= 1'b0;
      o_MEM_addr  <= 32'd0;
      o_MEM_wdata <= 32'd0;
      o_MEM_be    <= 4'h0;
      o_MEM_stall <= 1'b0;
      o_MEM_regWe <= 1'b0;
      o_MEM_WRA   <= 5'd0;
      o_MEM_WD    <= 32'd0;
      b_load      <= 1'b0;
      b_byte      <= 1'b0;
      b_wra       <= 5'd0;
    end else begin
      o_MEM_regWe <= 1'b0;
      case (state)
        IDLE: begin
          if (is_store || is_load) begin
            state       <= BUSY;
            o_MEM_req   <= 1'b1;
            o_MEM_stall <= 1'b1;
            o_MEM_we    <= is_store;
            b_load      <= is_load;
            b_byte      <= s_sbyte;
            b_wra       <= s_wra;
            if (s_sbyte) begin
              o_MEM_addr  <= s_alu;
              o_MEM_be    <= 4'b0001 << s_alu[1:0];
              o_MEM_wdata <= {4{s_rd2[7:0]}};
            end else begin
              o_MEM_addr  <= {s_alu[31:2], 2'b00};
              o_MEM_be    <= 4'hF;
              o_MEM_wdata <= s_rd2;
            end
          end else begin
            o_MEM_regWe <= s_reg_we;
            o_MEM_WRA   <= s_wra;
            o_MEM_WD    <= s_alu;
          end
        end
        BUSY: begin
          if (i_MEM_ack || expire) begin
            state       <= IDLE;
            o_MEM_req   <= 1'b0;
            o_MEM_we    <= 1'b0;
            o_MEM_addr  <= 32'd0;
            o_MEM_wdata <= 32'd0;
            o_MEM_be    <= 4'h0;
            o_MEM_stall <= 1'b0;
            if (i_MEM_ack && b_load) begin
              o_MEM_regWe <= 1'b1;
              o_MEM_WRA   <= b_wra;
              o_MEM_WD    <= load_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed vector table, reset/timeout sequences and randomized scoreboard for mem_stage.
module tb_mem_stage;

  logic        clk, rstn;
  logic        dmem_we, reg_we, sbyte, swrd;
  logic [4:0]  wra;
  logic [31:0] alu, rd2;
  logic        req, bus_we, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        wb_we, stall, err;
  logic [4:0]  wb_wra;
  logic [31:0] wb_wd;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn),
    .i_MEM_dmemWe(dmem_we), .i_MEM_regWe(reg_we), .i_MEM_sByte(sbyte), .i_MEM_sWRD(swrd),
    .i_MEM_WRA(wra), .i_MEM_aluOut(alu), .i_MEM_rd2(rd2),
    .o_MEM_req(req), .o_MEM_we(bus_we), .o_MEM_addr(addr), .o_MEM_wdata(wdata), .o_MEM_be(be),
    .i_MEM_ack(ack), .i_MEM_rdata(rdata),
    .o_MEM_regWe(wb_we), .o_MEM_WRA(wb_wra), .o_MEM_WD(wb_wd),
    .o_MEM_stall(stall), .o_MEM_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dmem, regwe, sbyte, swrd;
    logic [4:0]  wra;
    logic [31:0] alu, rd2, rdata;
    int          delay;
    logic        exp_mem, exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_regwe, chk_wd;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
  typedef struct { logic [4:0] wra; logic [31:0] wd; } wb_t;

  int     errors = 0;
  int     checks = 0;
  string  ctx = "init";
  logic   auto_resp = 1'b0;
  bit     in_req = 1'b0;
  int     wait_cnt = 0;
  bus_t   bus_q[$];
  wb_t    wb_q[$];
  vec_t   vecs[8];
  vec_t   nop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", ctx, name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic d, logic r, logic sb, logic sw, logic [4:0] w,
                              logic [31:0] a, logic [31:0] s, logic [31:0] rd, int dl,
                              logic em, logic ew, logic [31:0] ea, logic [3:0] eb, logic [31:0] ewd,
                              logic er, logic cw, logic [31:0] ed);
    vec_t v;
    v.dmem = d; v.regwe = r; v.sbyte = sb; v.swrd = sw; v.wra = w;
    v.alu = a; v.rd2 = s; v.rdata = rd; v.delay = dl;
    v.exp_mem = em; v.exp_we = ew; v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ewd;
    v.exp_regwe = er; v.chk_wd = cw; v.exp_wd = ed;
    return v;
  endfunction

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h8080_0080;
  endfunction

  task automatic drive(input vec_t v);
    dmem_we = v.dmem; reg_we = v.regwe; sbyte = v.sbyte; swrd = v.swrd;
    wra = v.wra; alu = v.alu; rd2 = v.rd2;
  endtask

  // Transaction-level expectation: what the bus and writeback port must show for one op.
  function automatic void model(input vec_t v);
    bus_t b;
    wb_t  w;
    logic [31:0] word, byte_val;
    bit st, ld;
    st = v.dmem;
    ld = v.regwe && v.swrd && !v.dmem;
    if (st || ld) begin
      b.we    = st;
      b.addr  = v.sbyte ? v.alu : (v.alu & 32'hFFFF_FFFC);
      b.be    = v.sbyte ? 4'(1 << v.alu[1:0]) : 4'hF;
      b.wdata = v.sbyte ? (32'(v.rd2[7:0]) * 32'h0101_0101) : v.rd2;
      bus_q.push_back(b);
      if (ld) begin
        word = mem_fn(v.alu);
        if (v.sbyte) begin
          byte_val = (word >> (8 * int'(v.alu[1:0]))) & 32'hFF;
          if (byte_val > 127) byte_val = byte_val + 32'hFFFF_FF00;
        end else begin
          byte_val = word;
        end
        w.wra = v.wra; w.wd = byte_val;
        wb_q.push_back(w);
      end
    end else if (v.regwe) begin
      w.wra = v.wra; w.wd = v.alu;
      wb_q.push_back(w);
    end
  endfunction

  // Random-phase memory responder and writeback/bus monitors.
  always @(negedge clk) begin
    if (auto_resp) begin
      if (!req) begin
        chk("idle_be", 32'(be), 32'h0);
        chk("idle_addr", addr, 32'h0);
        chk("idle_wdata", wdata, 32'h0);
      end else begin
        chk("bubble", 32'(wb_we), 32'h0);
      end
      if (wb_we) begin
        chk("wb_expected", 32'(wb_q.size() != 0), 32'h1);
        if (wb_q.size() != 0) begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_wra", 32'(wb_wra), 32'(w.wra));
          chk("wb_wd", wb_wd, w.wd);
        end
      end
      if (ack) begin
        ack = 1'b0;
      end else if (req) begin
        if (!in_req) begin
          in_req = 1'b1;
          wait_cnt = $urandom_range(0, 3);
          chk("bus_expected", 32'(bus_q.size() != 0), 32'h1);
          if (bus_q.size() != 0) begin
            bus_t b;
            b = bus_q.pop_front();
            chk("bus_we", 32'(bus_we), 32'(b.we));
            chk("bus_addr", addr, b.addr);
            chk("bus_be", 32'(be), 32'(b.be));
            chk("bus_wdata", wdata, b.wdata);
          end
        end
        if (wait_cnt == 0) begin
          ack = 1'b1;
          rdata = mem_fn(addr);
          in_req = 1'b0;
        end else begin
          wait_cnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        ack = 1'b1;
        rdata = $urandom;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int busy;
    logic bubble_ok;
    @(negedge clk); drive(v);
    @(negedge clk); drive(nop);
    @(negedge clk);
    if (v.exp_mem) begin
      chk("req", 32'(req), 32'h1);
      chk("we", 32'(bus_we), 32'(v.exp_we));
      chk("addr", addr, v.exp_addr);
      chk("be", 32'(be), 32'(v.exp_be));
      chk("wdata", wdata, v.exp_wdata);
      busy = 0;
      bubble_ok = 1'b1;
      while (stall && busy < 50) begin
        if (wb_we || !req) bubble_ok = 1'b0;
        if (busy == v.delay) begin ack = 1'b1; rdata = v.rdata; end
        busy++;
        @(negedge clk);
        ack = 1'b0; rdata = 32'h0;
      end
      chk("stall_cycles", 32'(busy), 32'(v.delay + 1));
      chk("bubble", 32'(bubble_ok), 32'h1);
    end
    chk("regwe", 32'(wb_we), 32'(v.exp_regwe));
    chk("stall_after", 32'(stall), 32'h0);
    chk("req_after", 32'(req), 32'h0);
    chk("be_after", 32'(be), 32'h0);
    if (v.chk_wd) begin
      chk("wra", 32'(wb_wra), 32'(v.wra));
      chk("wd", wb_wd, v.exp_wd);
    end
  endtask

  task automatic issue(input vec_t v);
    int g;
    g = 0;
    @(negedge clk);
    drive(v);
    while (stall && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("issue_timeout", 32'(stall), 32'h0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int g;
    nop = mk(0,0,0,0,5'd0,32'h0,32'h0,32'h0,0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0);
    vecs[0] = mk(0,1,0,0,5'd5, 32'h1234,     32'h0,        32'h0,        0, 0,0,32'h0,  4'h0,32'h0,        1,1,32'h1234);
    vecs[1] = mk(0,1,0,1,5'd9, 32'h103,      32'h55,       32'hDEADBEEF, 2, 1,0,32'h100,4'hF,32'h55,       1,1,32'hDEADBEEF);
    vecs[2] = mk(1,0,1,0,5'd3, 32'h22,       32'hA5,       32'h0,        0, 1,1,32'h22, 4'h4,32'hA5A5A5A5, 0,0,32'h0);
    vecs[3] = mk(0,1,1,1,5'd7, 32'h41,       32'h0,        32'h00008000, 1, 1,0,32'h41, 4'h2,32'h0,        1,1,32'hFFFFFF80);
    vecs[4] = mk(1,0,0,0,5'd0, 32'h207,      32'hCAFEF00D, 32'h0,        1, 1,1,32'h204,4'hF,32'hCAFEF00D, 0,0,32'h0);
    vecs[5] = mk(1,1,1,1,5'd12,32'h13,       32'h7F,       32'h11111111, 0, 1,1,32'h13, 4'h8,32'h7F7F7F7F, 0,0,32'h0);
    vecs[6] = mk(0,1,1,1,5'd2, 32'h3,        32'h12,       32'h7F000000, 0, 1,0,32'h3,  4'h8,32'h12121212, 1,1,32'h7F);
    vecs[7] = mk(0,0,0,1,5'd4, 32'hABCD0001, 32'h0,        32'h0,        0, 0,0,32'h0,  4'h0,32'h0,        0,1,32'hABCD0001);

    rstn = 1'b0; ack = 1'b0; rdata = 32'h0;
    drive(nop);
    dmem_we = 1'b1; reg_we = 1'b1; alu = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    ctx = "reset";
    chk("req", 32'(req), 32'h0);
    chk("we", 32'(bus_we), 32'h0);
    chk("addr", addr, 32'h0);
    chk("be", 32'(be), 32'h0);
    chk("stall", 32'(stall), 32'h0);
    chk("regwe", 32'(wb_we), 32'h0);
    chk("wra", 32'(wb_wra), 32'h0);
    chk("wd", wb_wd, 32'h0);
    chk("err", 32'(err), 32'h0);
    drive(nop);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    ctx = "reset_mid";
    v = mk(0,1,0,1,5'd6,32'h80,32'h0,32'h0,0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0);
    @(negedge clk); drive(v);
    @(negedge clk); drive(nop);
    @(negedge clk);
    chk("req_busy1", 32'(req), 32'h1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("req", 32'(req), 32'h0);
    chk("stall", 32'(stall), 32'h0);
    chk("regwe", 32'(wb_we), 32'h0);
    chk("addr", addr, 32'h0);
    chk("be", 32'(be), 32'h0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); ack = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk); ack = 1'b0;
    chk("late_ack_regwe", 32'(wb_we), 32'h0);
    chk("late_ack_req", 32'(req), 32'h0);
    chk("late_ack_stall", 32'(stall), 32'h0);

    ctx = "random";
    auto_resp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      v = nop;
      v.dmem  = 1'($urandom_range(0, 2) == 0);
      v.regwe = 1'($urandom_range(0, 1));
      v.sbyte = 1'($urandom_range(0, 1));
      v.swrd  = 1'($urandom_range(0, 1));
      v.wra   = 5'($urandom);
      v.alu   = $urandom;
      v.rd2   = $urandom;
      model(v);
      issue(v);
    end
    issue(nop);
    g = 0;
    while ((stall || req) && g < 100) begin @(negedge clk); g++; end
    repeat (4) @(negedge clk);
    auto_resp = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    chk("wb_drained", 32'(wb_q.size()), 32'h0);
    chk("bus_drained", 32'(bus_q.size()), 32'h0);
    chk("err_clear", 32'(err), 32'h0);

`ifdef MEM_TIMEOUT_EN
    ctx = "timeout";
    v = mk(0,1,0,1,5'd8,32'h300,32'h0,32'h0,0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0);
    @(negedge clk); drive(v);
    @(negedge clk); drive(nop);
    @(negedge clk);
    g = 0;
    while (req && g < 100) begin
      if (wb_we) chk("bubble", 32'(wb_we), 32'h0);
      g++;
      @(negedge clk);
    end
    chk("req_cycles", 32'(g), 32'd16);
    chk("err", 32'(err), 32'h1);
    chk("regwe", 32'(wb_we), 32'h0);
    chk("stall", 32'(stall), 32'h0);
    ctx = "after_timeout";
    run_vec(vecs[1]);
    run_vec(vecs[0]);
    chk("err_sticky", 32'(err), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
